// File: rtl/test_capture_buffer_pkg.sv
// Shared definitions for the AudioProcessing test-stream capture buffer
// (the audio test defs): FSM state encodings and the bit positions of the
// CPU-visible capture_ctrl and capture_status registers.
package test_capture_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  // capture_ctrl bit indices
  localparam int CTRL_ARM      = 0;
  localparam int CTRL_TRIG_EN  = 1;
  localparam int CTRL_CONT     = 2;
  localparam int CTRL_CLEAR    = 3;
  localparam int CTRL_DECIM_LO = 4;

  // capture_status bit indices
  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_ARMED     = 2;
  localparam int STAT_CAPTURING = 3;
  localparam int STAT_DONE      = 4;
  localparam int STAT_OVERFLOW  = 5;
  localparam int STAT_UNDERFLOW = 6;

endpackage

// File: rtl/test_capture_buffer_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
// Written for block-RAM inference, so there is no reset on storage or read data.
//  clk      in   clock
//  wr_en    in   write enable
//  wr_addr  in   write address
//  wr_data  in   write data
//  rd_addr  in   read address (read every cycle)
//  rd_q     out  registered read data, one clk after rd_addr
module test_capture_buffer_ram #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_q
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_q <= mem[rd_addr];
  end

endmodule

// File: rtl/test_capture_buffer.sv
// Reader end of the AudioProcessing test stream. Captures din words on each
// din_valid strobe into an on-chip FIFO, with arm / trigger / decimation and
// one-shot or continuous capture. The CPU drains the FIFO via byte registers.
//  clk, reset      clock, synchronous active-high reset
//  din_valid, din  capture strobe and data
//  trig_in         trigger level
//  capture_ctrl    [0] arm [1] trig_en [2] continuous [3] clear [7:4] decim
//  rd_strobe       CPU pop pulse
//  rd_lsb_data     head word [7:0]
//  rd_msb_data     head word [15:8]
//  capture_status  [0] empty [1] full [2] armed [3] capturing [4] done
//                  [5] overflow [6] underflow [7] 0
//  word_count      words held
module test_capture_buffer
  import test_capture_buffer_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                din_valid,
  input  logic [DATA_W-1:0]   din,
  input  logic                trig_in,
  input  logic [7:0]          capture_ctrl,
  input  logic                rd_strobe,
  output logic [7:0]          rd_lsb_data,
  output logic [7:0]          rd_msb_data,
  output logic [7:0]          capture_status,
  output logic [DEPTH_LOG2:0] word_count
);

  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(1) << DEPTH_LOG2;

  cap_state_e state, state_nxt;

  // Pointers carry one extra MSB so that full and empty are distinguishable.
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, count, count_nxt;
  logic [3:0]        decim_cnt;
  logic              ovf, udf;
  logic              rd_vld_p1;
  logic [DATA_W-1:0] ram_q_p1, head_p2;

  logic       arm, trig_en, cont, clr;
  logic [3:0] decim;
  logic       empty, full, pop, entry, in_capture, store, wr_en;

  assign arm     = capture_ctrl[CTRL_ARM];
  assign trig_en = capture_ctrl[CTRL_TRIG_EN];
  assign cont    = capture_ctrl[CTRL_CONT];
  assign clr     = capture_ctrl[CTRL_CLEAR];
  assign decim   = capture_ctrl[CTRL_DECIM_LO +: 4];

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);
  assign pop   = rd_strobe && !empty;

  // The entry word is always stored; after that one word per (decim+1) strobes.
  assign entry      = (state == ST_ARMED) && arm && din_valid && (!trig_en || trig_in);
  assign in_capture = (state == ST_CAPTURE) && arm && din_valid;
  assign store      = entry || (in_capture && (decim_cnt >= decim));
  // A simultaneous pop frees a slot, so a write is still legal when full.
  assign wr_en      = store && (!full || pop) && !clr;
  assign count_nxt  = count + PTR_W'(wr_en) - PTR_W'(pop);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (arm) state_nxt = ST_ARMED;
      ST_ARMED:   if (!arm) state_nxt = ST_IDLE;
                  else if (entry) state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (!arm) state_nxt = ST_IDLE;
                  else if (!cont && (count_nxt == DEPTH_CNT)) state_nxt = ST_DONE;
      ST_DONE:    if (!arm) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (clr) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      decim_cnt <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        decim_cnt <= '0;
        ovf       <= 1'b0;
        udf       <= 1'b0;
        rd_vld_p1 <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        if (entry)
          decim_cnt <= '0;
        else if (in_capture)
          decim_cnt <= (decim_cnt >= decim) ? 4'd0 : decim_cnt + 4'd1;
        if (store && full && !pop) ovf <= 1'b1;
        if (rd_strobe && empty)    udf <= 1'b1;
        // RAM data is only meaningful when the FIFO held a word at read time;
        // otherwise the head register keeps its last value.
        rd_vld_p1 <= !empty;
      end
    end
  end

  // Stage p1: registered RAM read of the word at rd_ptr
  test_capture_buffer_ram #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr[DEPTH_LOG2-1:0]),
    .wr_data(din),
    .rd_addr(rd_ptr[DEPTH_LOG2-1:0]),
    .rd_q   (ram_q_p1)
  );

  // Stage p2: CPU-visible head register
  always_ff @(posedge clk) begin
    if (reset)          head_p2 <= '0;
    else if (rd_vld_p1) head_p2 <= ram_q_p1;
  end

  assign rd_lsb_data = head_p2[7:0];
  assign rd_msb_data = head_p2[15:8];
  assign word_count  = count;

  always_comb begin
    capture_status                 = 8'h00;
    capture_status[STAT_EMPTY]     = empty;
    capture_status[STAT_FULL]      = full;
    capture_status[STAT_ARMED]     = (state == ST_ARMED);
    capture_status[STAT_CAPTURING] = (state == ST_CAPTURE);
    capture_status[STAT_DONE]      = (state == ST_DONE);
    capture_status[STAT_OVERFLOW]  = ovf;
    capture_status[STAT_UNDERFLOW] = udf;
  end

endmodule

// File: tb/tb_test_capture_buffer.sv
module tb_test_capture_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        din_valid;
  logic [15:0] din;
  logic        trig_in;
  logic [7:0]  capture_ctrl;
  logic        rd_strobe;
  logic [7:0]  rd_lsb_data, rd_msb_data, capture_status;
  logic [9:0]  word_count;
  logic [15:0] head;

  int checks = 0;
  int errors = 0;

  assign head = {rd_msb_data, rd_lsb_data};

  always #5 clk = ~clk;

  test_capture_buffer #(.DATA_W(16), .DEPTH_LOG2(9)) dut (
    .clk           (clk),
    .reset         (reset),
    .din_valid     (din_valid),
    .din           (din),
    .trig_in       (trig_in),
    .capture_ctrl  (capture_ctrl),
    .rd_strobe     (rd_strobe),
    .rd_lsb_data   (rd_lsb_data),
    .rd_msb_data   (rd_msb_data),
    .capture_status(capture_status),
    .word_count    (word_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] d, input logic t);
    din = d; trig_in = t; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
  endtask

  // Pop, then wait until the new head is visible.
  task automatic pop_word();
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    tick();
    tick();
  endtask

  task automatic clear_pulse();
    capture_ctrl = 8'h08;
    tick();
    capture_ctrl = 8'h00;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; din_valid = 1'b0; din = '0; trig_in = 1'b0;
    capture_ctrl = 8'h00; rd_strobe = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (capture_status !== 8'h01) begin errors++; $display("FAIL reset_status: got %h want 01", capture_status); end
    checks++;
    if (word_count !== 10'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", word_count); end
    checks++;
    if (head !== 16'h0000) begin errors++; $display("FAIL reset_head: got %h want 0000", head); end
  endtask

  task automatic test_oneshot();
    int bad = 0;
    logic [15:0] bad_got = '0, bad_want = '0;
    capture_ctrl = 8'h01;
    tick();
    checks++;
    if (capture_status !== 8'h05) begin errors++; $display("FAIL oneshot_armed: got %h want 05", capture_status); end
    for (int n = 0; n < 600; n++) strobe(16'h1000 + 16'(n), 1'b0);
    checks++;
    if (word_count !== 10'd512) begin errors++; $display("FAIL oneshot_count: got %0d want 512", word_count); end
    checks++;
    if (capture_status !== 8'h12) begin errors++; $display("FAIL oneshot_status: got %h want 12", capture_status); end
    for (int i = 0; i < 512; i++) begin
      if (head !== 16'h1000 + 16'(i)) begin
        if (bad == 0) begin bad_got = head; bad_want = 16'h1000 + 16'(i); end
        bad++;
      end
      pop_word();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL oneshot_order: %0d bad words, first got %h want %h", bad, bad_got, bad_want); end
    checks++;
    if (capture_status !== 8'h11) begin errors++; $display("FAIL oneshot_drained: got %h want 11", capture_status); end
    capture_ctrl = 8'h00;
    tick();
    checks++;
    if (capture_status !== 8'h01) begin errors++; $display("FAIL oneshot_idle: got %h want 01", capture_status); end
  endtask

  task automatic test_trigger();
    capture_ctrl = 8'h03;
    tick();
    for (int n = 0; n < 10; n++) strobe(16'(n), 1'b0);
    checks++;
    if (word_count !== 10'd0) begin errors++; $display("FAIL trig_wait_count: got %0d want 0", word_count); end
    checks++;
    if (capture_status !== 8'h05) begin errors++; $display("FAIL trig_wait_status: got %h want 05", capture_status); end
    strobe(16'hA5A5, 1'b1);
    checks++;
    if (word_count !== 10'd1) begin errors++; $display("FAIL trig_count1: got %0d want 1", word_count); end
    checks++;
    if (capture_status !== 8'h08) begin errors++; $display("FAIL trig_status: got %h want 08", capture_status); end
    tick();
    checks++;
    if (head !== 16'hA5A5) begin errors++; $display("FAIL trig_head: got %h want a5a5", head); end
    strobe(16'hB000, 1'b0);
    strobe(16'hB001, 1'b0);
    checks++;
    if (word_count !== 10'd3) begin errors++; $display("FAIL trig_count3: got %0d want 3", word_count); end
    pop_word();
    checks++;
    if (head !== 16'hB000) begin errors++; $display("FAIL trig_second: got %h want b000", head); end
    capture_ctrl = 8'h00;
    tick();
    checks++;
    if (capture_status !== 8'h00 || word_count !== 10'd2) begin
      errors++; $display("FAIL trig_disarm: got status %h count %0d want 00 / 2", capture_status, word_count);
    end
    clear_pulse();
    checks++;
    if (word_count !== 10'd0) begin errors++; $display("FAIL trig_clear: got %0d want 0", word_count); end
  endtask

  task automatic test_decim();
    int bad = 0;
    capture_ctrl = 8'h31;
    tick();
    for (int n = 0; n < 40; n++) strobe(16'(n), 1'b0);
    checks++;
    if (word_count !== 10'd10) begin errors++; $display("FAIL decim_count: got %0d want 10", word_count); end
    tick();
    for (int i = 0; i < 10; i++) begin
      if (head !== 16'(4 * i)) begin
        $display("FAIL decim_word%0d: got %h want %h", i, head, 16'(4 * i));
        bad++;
      end
      pop_word();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL decim_order: %0d bad words want 0", bad); end
    capture_ctrl = 8'h00;
    tick();
  endtask

  task automatic test_continuous();
    capture_ctrl = 8'h05;
    tick();
    for (int n = 0; n < 520; n++) strobe(16'h2000 + 16'(n), 1'b0);
    checks++;
    if (word_count !== 10'd512) begin errors++; $display("FAIL cont_count: got %0d want 512", word_count); end
    checks++;
    if (capture_status !== 8'h2A) begin errors++; $display("FAIL cont_status: got %h want 2a", capture_status); end
    din = 16'h2300; din_valid = 1'b1; rd_strobe = 1'b1;
    tick();
    din_valid = 1'b0; rd_strobe = 1'b0;
    checks++;
    if (word_count !== 10'd512) begin errors++; $display("FAIL cont_pop_write: got %0d want 512", word_count); end
    tick();
    tick();
    checks++;
    if (head !== 16'h2001) begin errors++; $display("FAIL cont_head: got %h want 2001", head); end
    checks++;
    if (capture_status !== 8'h2A) begin errors++; $display("FAIL cont_status2: got %h want 2a", capture_status); end
    capture_ctrl = 8'h00;
    tick();
    checks++;
    if (capture_status !== 8'h22) begin errors++; $display("FAIL cont_disarm: got %h want 22", capture_status); end
    clear_pulse();
    checks++;
    if (capture_status !== 8'h01 || word_count !== 10'd0) begin
      errors++; $display("FAIL cont_clear: got status %h count %0d want 01 / 0", capture_status, word_count);
    end
  endtask

  task automatic test_underflow();
    capture_ctrl = 8'h01;
    tick();
    strobe(16'h5A3C, 1'b0);
    capture_ctrl = 8'h00;
    tick();
    tick();
    checks++;
    if (head !== 16'h5A3C || word_count !== 10'd1) begin
      errors++; $display("FAIL udf_setup: got head %h count %0d want 5a3c / 1", head, word_count);
    end
    pop_word();
    checks++;
    if (capture_status !== 8'h01 || head !== 16'h5A3C) begin
      errors++; $display("FAIL udf_last_pop: got status %h head %h want 01 / 5a3c", capture_status, head);
    end
    pop_word();
    checks++;
    if (capture_status !== 8'h41) begin errors++; $display("FAIL udf_status: got %h want 41", capture_status); end
    checks++;
    if (head !== 16'h5A3C) begin errors++; $display("FAIL udf_head_held: got %h want 5a3c", head); end
    clear_pulse();
    checks++;
    if (capture_status !== 8'h01 || word_count !== 10'd0) begin
      errors++; $display("FAIL udf_clear: got status %h count %0d want 01 / 0", capture_status, word_count);
    end
  endtask

  task automatic test_mid_reset();
    capture_ctrl = 8'h01;
    tick();
    for (int n = 0; n < 100; n++) strobe(16'h7700 + 16'(n), 1'b0);
    checks++;
    if (word_count !== 10'd100 || capture_status !== 8'h08) begin
      errors++; $display("FAIL mid_setup: got count %0d status %h want 100 / 08", word_count, capture_status);
    end
    checks++;
    if (head !== 16'h7700) begin errors++; $display("FAIL mid_head: got %h want 7700", head); end
    reset = 1'b1;
    capture_ctrl = 8'h00;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (capture_status !== 8'h01 || word_count !== 10'd0) begin
      errors++; $display("FAIL mid_reset: got status %h count %0d want 01 / 0", capture_status, word_count);
    end
    checks++;
    if (head !== 16'h0000) begin errors++; $display("FAIL mid_reset_head: got %h want 0000", head); end
    capture_ctrl = 8'h01;
    tick();
    for (int n = 0; n < 3; n++) strobe(16'h8800 + 16'(n), 1'b0);
    tick();
    checks++;
    if (word_count !== 10'd3 || head !== 16'h8800) begin
      errors++; $display("FAIL mid_rearm: got count %0d head %h want 3 / 8800", word_count, head);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_trigger();
    test_decim();
    test_continuous();
    test_underflow();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
